// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request and byte-memory bus interfaces for mem_access_unit
interface mem_access_req_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface mem_access_mem_if #(
    parameter int ADDR_W = 8
);
    logic              mem_enable;
    logic              mem_readwrite;
    logic              mem_signextend;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_datain;
    logic [31:0]       mem_dataout;

    modport master (
        output mem_enable, mem_readwrite, mem_signextend, mem_size, mem_address, mem_datain,
        input  mem_dataout
    );

    modport slave (
        input  mem_enable, mem_readwrite, mem_signextend, mem_size, mem_address, mem_datain,
        output mem_dataout
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine issuing big-endian single-byte memory accesses
module mem_access_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_req_if.slave   req,
    mem_access_mem_if.master  mem
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic              wr_q;
    logic              sgn_q;
    logic              err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       acc;
    logic [1:0]        idx;
    logic [1:0]        last_idx;

    logic              in_xfer;
    logic [1:0]        byte_sel;
    logic [31:0]       wshift;
    logic [31:0]       rdata;
    logic              unused_dataout_hi;

    assign in_xfer = (state == XFER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            sgn_q    <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            acc      <= 32'h0;
            idx      <= 2'd0;
            last_idx <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        wr_q    <= req.req_write;
                        sgn_q   <= req.req_signed;
                        size_q  <= req.req_size;
                        addr_q  <= req.req_addr;
                        wdata_q <= req.req_wdata;
                        acc     <= 32'h0;
                        idx     <= 2'd0;
                        err_q   <= (req.req_size == 2'b11);
                        case (req.req_size)
                            2'b00:   last_idx <= 2'd0;
                            2'b01:   last_idx <= 2'd1;
                            default: last_idx <= 2'd3;
                        endcase
                        state <= (req.req_size == 2'b11) ? DONE : XFER;
                    end
                end
                XFER: begin
                    // Big-endian: first byte fetched ends up most significant
                    if (!wr_q) begin
                        acc <= {acc[23:0], mem.mem_dataout[7:0]};
                    end
                    idx <= idx + 2'd1;
                    if (idx == last_idx) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand byte for the current step, counted from the least significant end
    assign byte_sel = last_idx - idx;
    assign wshift   = wdata_q >> {byte_sel, 3'b000};

    assign mem.mem_enable     = in_xfer;
    assign mem.mem_readwrite  = in_xfer & wr_q;
    assign mem.mem_signextend = 1'b0;
    assign mem.mem_size       = 2'b00;
    assign mem.mem_address    = in_xfer ? (addr_q + ADDR_W'(idx)) : '0;
    assign mem.mem_datain     = (in_xfer && wr_q) ? {24'h0, wshift[7:0]} : 32'h0;

    always_comb begin
        rdata = 32'h0;
        if (state == DONE && !wr_q && !err_q) begin
            case (size_q)
                2'b00:   rdata = sgn_q ? {{24{acc[7]}}, acc[7:0]} : {24'h0, acc[7:0]};
                2'b01:   rdata = sgn_q ? {{16{acc[15]}}, acc[15:0]} : {16'h0, acc[15:0]};
                default: rdata = acc;
            endcase
        end
    end

    assign req.req_ready  = (state == IDLE) && !reset;
    assign req.resp_valid = (state == DONE);
    assign req.resp_err   = (state == DONE) && err_q;
    assign req.resp_rdata = rdata;

    assign unused_dataout_hi = ^mem.mem_dataout[31:8];

endmodule
